// File: rtl/boxcar_pkg.sv
// Shared types and helpers for the boxcar running-sum accumulator.
package boxcar_pkg;

  // Window fill state: FILL until SIZE real samples have entered, then RUN.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Accumulator width needed to hold SIZE samples of WIDTH bits without wrap.
  function automatic int sumw_f(input int width, input int size);
    return width + $clog2(size);
  endfunction

endpackage : boxcar_pkg

// File: rtl/boxcar_accum.sv
// Boxcar (moving-window) accumulator fed by an external SIZE-deep shift
// register: sample_in enters the window, sample_old leaves it.
// Optional build macro BOXCAR_ROUND_EN: round-to-nearest average with
// saturation instead of plain truncation.
module boxcar_accum
  import boxcar_pkg::*;
#(
  parameter int SIZE  = 8,
  parameter int WIDTH = 8,
  localparam int SUMW = sumw_f(WIDTH, SIZE)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             CLK_en,
  input  logic             flush,
  input  logic [WIDTH-1:0] sample_in,
  input  logic [WIDTH-1:0] sample_old,
  output logic [SUMW-1:0]  sum_out,
  output logic [WIDTH-1:0] avg_out,
  output logic             valid
);

  localparam int SHIFT = $clog2(SIZE);
  localparam logic [SHIFT-1:0] CNT_MAX  = SHIFT'(SIZE - 1);
  localparam logic [SHIFT-1:0] CNT_ONE  = SHIFT'(1);
  localparam logic [SHIFT-1:0] CNT_ZERO = SHIFT'(0);
  localparam logic [SUMW-1:0]  SUM_ZERO = SUMW'(0);
  localparam logic [SUMW:0]    HALF     = (SUMW + 1)'(SIZE / 2);

  state_e           state_q, state_d;
  logic [SHIFT-1:0] fill_cnt_q, fill_cnt_d;
  logic [SUMW-1:0]  sum_q, sum_d;
  logic [WIDTH-1:0] avg_q, avg_d;
  logic             valid_q, valid_d;

  logic [SUMW-1:0]  in_ext_s;
  logic [SUMW-1:0]  old_ext_s;

  assign in_ext_s  = {{SHIFT{1'b0}}, sample_in};
  assign old_ext_s = {{SHIFT{1'b0}}, sample_old};

  // Divide the window sum by SIZE; rounding build adds SIZE/2 one bit wider
  // and clamps to the sample range.
  function automatic logic [WIDTH-1:0] avg_f(input logic [SUMW-1:0] s);
`ifdef BOXCAR_ROUND_EN
    logic [SUMW:0] sh;
    sh = ({1'b0, s} + HALF) >> SHIFT;
    if (|sh[SUMW:WIDTH]) begin
      return {WIDTH{1'b1}};
    end else begin
      return sh[WIDTH-1:0];
    end
`else
    return WIDTH'(s >> SHIFT);
`endif
  endfunction

  // Next-state logic: flush beats the enable; FILL ignores the stale sample_old.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    sum_d      = sum_q;
    avg_d      = avg_q;
    valid_d    = valid_q;
    if (flush) begin
      state_d    = FILL;
      fill_cnt_d = CNT_ZERO;
      sum_d      = SUM_ZERO;
      avg_d      = {WIDTH{1'b0}};
      valid_d    = 1'b0;
    end else if (CLK_en) begin
      case (state_q)
        FILL: begin
          sum_d = sum_q + in_ext_s;
          if (fill_cnt_q == CNT_MAX) begin
            state_d    = RUN;
            fill_cnt_d = CNT_ZERO;
            valid_d    = 1'b1;
          end else begin
            fill_cnt_d = fill_cnt_q + CNT_ONE;
            valid_d    = 1'b0;
          end
        end
        RUN: begin
          sum_d   = sum_q + in_ext_s - old_ext_s;
          valid_d = 1'b1;
        end
        default: begin
          state_d    = FILL;
          fill_cnt_d = CNT_ZERO;
          sum_d      = SUM_ZERO;
          valid_d    = 1'b0;
        end
      endcase
      avg_d = avg_f(sum_d);
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= FILL;
      fill_cnt_q <= CNT_ZERO;
      sum_q      <= SUM_ZERO;
      avg_q      <= {WIDTH{1'b0}};
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      sum_q      <= sum_d;
      avg_q      <= avg_d;
      valid_q    <= valid_d;
    end
  end

  assign sum_out = sum_q;
  assign avg_out = avg_q;
  assign valid   = valid_q;

endmodule : boxcar_accum

// File: tb/tb_boxcar_accum.sv
// Scoreboard bench for boxcar_accum (SIZE=8, WIDTH=8); expected avg honours
// BOXCAR_ROUND_EN when the build defines it.
module tb_boxcar_accum;

  localparam int SIZE  = 8;
  localparam int WIDTH = 8;
  localparam int SUMW  = 11;

  logic             CLK = 1'b0;
  logic             reset;
  logic             CLK_en;
  logic             flush;
  logic [WIDTH-1:0] sample_in;
  logic [WIDTH-1:0] sample_old;
  logic [SUMW-1:0]  sum_out;
  logic [WIDTH-1:0] avg_out;
  logic             valid;

  typedef struct packed {
    logic [SUMW-1:0]  s;
    logic [WIDTH-1:0] a;
    logic             v;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         vec_idx = 0;
  logic [7:0] sr [0:7];

  boxcar_accum #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .CLK_en    (CLK_en),
    .flush     (flush),
    .sample_in (sample_in),
    .sample_old(sample_old),
    .sum_out   (sum_out),
    .avg_out   (avg_out),
    .valid     (valid)
  );

  always #5 CLK = ~CLK;

  // Expected average for a given window sum.
  function automatic logic [7:0] exp_avg(input int s);
    int r;
`ifdef BOXCAR_ROUND_EN
    r = (s + 4) / 8;
`else
    r = s / 8;
`endif
    if (r > 255) r = 255;
    return 8'(r);
  endfunction

  // One clock of stimulus; the upstream shift register model supplies sample_old.
  task automatic step(input logic rst_n, input logic en, input logic fl,
                      input logic [7:0] din, input int exp_s, input logic exp_v);
    exp_t e;
    @(negedge CLK);
    reset      = rst_n;
    CLK_en     = en;
    flush      = fl;
    sample_in  = din;
    sample_old = sr[7];
    @(posedge CLK);
    if (en) begin
      for (int i = 7; i > 0; i--) sr[i] = sr[i-1];
      sr[0] = din;
    end
    #1;
    e.s = 11'(exp_s);
    e.a = exp_avg(exp_s);
    e.v = exp_v;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are stable at the falling edge after each driven edge.
  always @(negedge CLK) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vec_idx++;
      checks++;
      if (sum_out !== e.s) begin
        errors++;
        $display("FAIL sum_out vec %0d: got %0d expected %0d", vec_idx, sum_out, e.s);
      end
      checks++;
      if (avg_out !== e.a) begin
        errors++;
        $display("FAIL avg_out vec %0d: got %0d expected %0d", vec_idx, avg_out, e.a);
      end
      checks++;
      if (valid !== e.v) begin
        errors++;
        $display("FAIL valid vec %0d: got %0d expected %0d", vec_idx, valid, e.v);
      end
    end
  end

  initial begin
    logic [7:0] pat [0:7];
    int         psum [0:7];
    pat  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd2};
    psum = '{1, 2, 3, 4, 6, 8, 10, 12};
    for (int i = 0; i < 8; i++) sr[i] = 8'hAA;
    reset      = 1'b0;
    CLK_en     = 1'b0;
    flush      = 1'b0;
    sample_in  = 8'd0;
    sample_old = 8'd0;

    // Reset held two cycles; it overrides flush and enable.
    step(1'b0, 1'b1, 1'b1, 8'd77, 0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'd77, 0, 1'b0);

    // Fill with 10s: valid on the 8th, then steady at 80 / 10.
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b1, 1'b0, 8'd10, 10 * k, k == 8);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, 8'd10, 80, 1'b1);

    // Enable low while inputs wander: everything holds.
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 8'(200 + k * 7), 80, 1'b1);

    // Flush with enable in RUN: clear, then eight fresh 255s needed.
    step(1'b1, 1'b1, 1'b1, 8'd99, 0, 1'b0);
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b1, 1'b0, 8'd255, 255 * k, k == 8);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 8'd255, 2040, 1'b1);

    // Flush alone, then the {1,1,1,1,2,2,2,2} window (sum 12).
    step(1'b1, 1'b0, 1'b1, 8'd0, 0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, pat[k], psum[k], k == 7);
    step(1'b1, 1'b1, 1'b0, 8'd5, 16, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'd50, 65, 1'b1);

    // Reset mid-window with flush also high; refill from scratch with 3s.
    step(1'b0, 1'b1, 1'b1, 8'd50, 0, 1'b0);
    for (int k = 1; k <= 8; k++) step(1'b1, 1'b1, 1'b0, 8'd3, 3 * k, k == 8);
    step(1'b1, 1'b1, 1'b0, 8'd3, 24, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_boxcar_accum
